// File: rtl/alu_upper_immediate_decode.sv
// U-type (AUIPC/LUI) decode stage with a two-entry output/skid buffer.
// Optional trap reporting for non-32-bit words is enabled by defining UTYPE_ILLEGAL_TRAP_EN.
module alu_upper_immediate_decode #(
  parameter int DROP_X0     = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        enable_auipc,
  output logic        enable_lui,
  output logic [31:0] immediate20_utype,
  output logic [4:0]  rd_index,
  output logic [31:0] pc
`ifdef UTYPE_ILLEGAL_TRAP_EN
  ,
  output logic        illegal_valid,
  output logic [31:0] illegal_pc
`endif
);

  localparam logic [4:0] OPC_AUIPC = 5'h05;
  localparam logic [4:0] OPC_LUI   = 5'h0D;

  typedef struct packed {
    logic        auipc;
    logic        lui;
    logic [19:0] imm20;
    logic [4:0]  rd;
    logic [31:0] pc;
  } entry_t;

  localparam entry_t EMPTY_ENTRY = '0;

  logic   out_valid_q;
  logic   skid_valid_q;
  entry_t out_q;
  entry_t skid_q;

  logic   is_32bit;
  logic   is_auipc;
  logic   is_lui;
  logic   rd_is_x0;
  logic   issuable;
  logic   accept;
  logic   push;
  logic   advance;
  entry_t new_entry;

  // Decode is combinational on the incoming word; only issuable U-type words become entries.
  always_comb begin
    is_32bit  = (in_instr[1:0] == 2'b11);
    is_auipc  = is_32bit && (in_instr[6:2] == OPC_AUIPC);
    is_lui    = is_32bit && (in_instr[6:2] == OPC_LUI);
    rd_is_x0  = (in_instr[11:7] == 5'd0);
    issuable  = (is_auipc || is_lui) && !((DROP_X0 != 0) && rd_is_x0);
    accept    = in_valid && in_ready;
    push      = accept && issuable;
    advance   = !out_valid_q || out_ready;
    new_entry = EMPTY_ENTRY;
    new_entry.auipc = is_auipc;
    new_entry.lui   = is_lui;
    new_entry.imm20 = in_instr[31:12];
    new_entry.rd    = in_instr[11:7];
    new_entry.pc    = in_pc;
  end

  assign in_ready          = !skid_valid_q;
  assign out_valid         = out_valid_q;
  assign enable_auipc      = out_q.auipc;
  assign enable_lui        = out_q.lui;
  assign immediate20_utype = {out_q.imm20, 12'h000};
  assign rd_index          = out_q.rd;
  assign pc                = out_q.pc;

  // The skid entry always drains before a new push can land, keeping strict FIFO order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= EMPTY_ENTRY;
      skid_q       <= EMPTY_ENTRY;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q.auipc  <= 1'b0;
      out_q.lui    <= 1'b0;
    end else if (advance) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (push) begin
        out_q       <= new_entry;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
        out_q.auipc <= 1'b0;
        out_q.lui   <= 1'b0;
      end
    end else if (push) begin
      skid_q       <= new_entry;
      skid_valid_q <= 1'b1;
    end
  end

`ifdef UTYPE_ILLEGAL_TRAP_EN
  // One-cycle pulse for accepted compressed/non-32-bit encodings; pc is held between pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      illegal_valid <= 1'b0;
      illegal_pc    <= 32'd0;
    end else begin
      illegal_valid <= accept && !is_32bit && !flush;
      if (accept && !is_32bit && !flush) begin
        illegal_pc <= in_pc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_upper_immediate_decode.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_alu_upper_immediate_decode;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic        enable_auipc;
  logic        enable_lui;
  logic [31:0] immediate20_utype;
  logic [4:0]  rd_index;
  logic [31:0] pc;
`ifdef UTYPE_ILLEGAL_TRAP_EN
  logic        illegal_valid;
  logic [31:0] illegal_pc;
  bit          exp_illegal;
  logic [31:0] exp_illegal_pc;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          auipc;
    bit          lui;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];

  always #5 clock = ~clock;

  alu_upper_immediate_decode dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .enable_auipc(enable_auipc), .enable_lui(enable_lui),
    .immediate20_utype(immediate20_utype), .rd_index(rd_index), .pc(pc)
`ifdef UTYPE_ILLEGAL_TRAP_EN
    , .illegal_valid(illegal_valid), .illegal_pc(illegal_pc)
`endif
  );

  task automatic drive(input bit v, input logic [31:0] instr, input logic [31:0] p);
    in_valid = v;
    in_instr = instr;
    in_pc    = p;
  endtask

  // Advances one clock; the model is a FIFO of at most two entries, full means not ready.
  task automatic step();
    ent_t        e;
    bit          acc;
    bit          iss;
    bit          fl;
    bit          ordy;
    logic [31:0] ipc;
    logic [31:0] word;
    word = in_instr;
    ipc  = in_pc;
    fl   = flush;
    ordy = out_ready;
    acc  = in_valid && (mq.size() < 2);
    e.auipc = (word[6:0] == 7'h17);
    e.lui   = (word[6:0] == 7'h37);
    e.imm   = word & 32'hFFFF_F000;
    e.rd    = word[11:7];
    e.pc    = ipc;
    iss = (e.auipc || e.lui) && (e.rd != 5'd0);
    @(posedge clock);
    if (fl) mq.delete();
    else begin
      if (mq.size() > 0 && ordy) void'(mq.pop_front());
      if (acc && iss) mq.push_back(e);
    end
`ifdef UTYPE_ILLEGAL_TRAP_EN
    exp_illegal = acc && !fl && (word[1:0] != 2'b11);
    if (exp_illegal) exp_illegal_pc = ipc;
`endif
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (enable_auipc !== 1'b0 || enable_lui !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_enables: got %b%b want 00", enable_auipc, enable_lui); end
    n_checks++; if (immediate20_utype !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_imm: got %h want 0", immediate20_utype); end
    n_checks++; if (rd_index !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_rd: got %0d want 0", rd_index); end
    n_checks++; if (pc !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_pc: got %h want 0", pc); end
`ifdef UTYPE_ILLEGAL_TRAP_EN
    n_checks++; if (illegal_valid !== 1'b0 || illegal_pc !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_illegal: got %b %h want 0 0", illegal_valid, illegal_pc); end
    exp_illegal = 1'b0; exp_illegal_pc = 32'd0;
`endif
    #1 reset_n = 1'b1;
    mq.delete();
    @(posedge clock); #1;
  endtask

  task automatic test_auipc();
    out_ready = 1'b1;
    drive(1'b1, 32'h1234_5297, 32'h0000_0100);
    step();
    drive(1'b0, 32'd0, 32'd0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL auipc_valid: got %b want 1", out_valid); end
    n_checks++; if (enable_auipc !== 1'b1 || enable_lui !== 1'b0) begin n_fail++; $display("[TB] FAIL auipc_enables: got %b%b want 10", enable_auipc, enable_lui); end
    n_checks++; if (immediate20_utype !== 32'h1234_5000) begin n_fail++; $display("[TB] FAIL auipc_imm: got %h want 12345000", immediate20_utype); end
    n_checks++; if (rd_index !== 5'd5 || pc !== 32'h100) begin n_fail++; $display("[TB] FAIL auipc_rd_pc: got %0d %h want 5 100", rd_index, pc); end
    step();
    n_checks++; if (out_valid !== 1'b0 || enable_auipc !== 1'b0) begin n_fail++; $display("[TB] FAIL auipc_drain: got %b %b want 0 0", out_valid, enable_auipc); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, 32'hABCD_E0B7, 32'h0000_0104);
    step();
    drive(1'b1, 32'h0000_1297, 32'h0000_0108);
    n_checks++; if (out_valid !== 1'b1 || enable_lui !== 1'b1 || enable_auipc !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_first_kind: got v%b lui%b auipc%b want 1 1 0", out_valid, enable_lui, enable_auipc); end
    n_checks++; if (immediate20_utype !== 32'hABCD_E000 || rd_index !== 5'd1 || pc !== 32'h104) begin n_fail++; $display("[TB] FAIL b2b_first_fields: got %h %0d %h want abcde000 1 104", immediate20_utype, rd_index, pc); end
    step();
    drive(1'b0, 32'd0, 32'd0);
    n_checks++; if (out_valid !== 1'b1 || enable_auipc !== 1'b1 || enable_lui !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_second_kind: got v%b auipc%b lui%b want 1 1 0", out_valid, enable_auipc, enable_lui); end
    n_checks++; if (immediate20_utype !== 32'h0000_1000 || rd_index !== 5'd5 || pc !== 32'h108) begin n_fail++; $display("[TB] FAIL b2b_second_fields: got %h %0d %h want 00001000 5 108", immediate20_utype, rd_index, pc); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(1'b1, 32'h1111_1297, 32'h300); step();
    drive(1'b1, 32'h2222_2297, 32'h304); step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_full_ready: got %b want 0", in_ready); end
    drive(1'b1, 32'h3333_3297, 32'h308);
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_hold_flags: got rdy%b v%b want 0 1", in_ready, out_valid); end
      n_checks++; if (pc !== 32'h300 || immediate20_utype !== 32'h1111_1000) begin n_fail++; $display("[TB] FAIL stall_hold_fields: got %h %h want 300 11111000", pc, immediate20_utype); end
    end
    out_ready = 1'b1;
    step();
    n_checks++; if (pc !== 32'h304 || out_valid !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_skid_move: got %h v%b rdy%b want 304 1 1", pc, out_valid, in_ready); end
    step();
    drive(1'b0, 32'd0, 32'd0);
    n_checks++; if (pc !== 32'h308 || immediate20_utype !== 32'h3333_3000 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_third: got %h %h v%b want 308 33333000 1", pc, immediate20_utype, out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_filter();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0013, 32'h1F0); step();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL filter_addi: got v%b rdy%b want 0 1", out_valid, in_ready); end
    drive(1'b1, 32'h0000_0017, 32'h1F4); step();
    drive(1'b0, 32'd0, 32'd0);
    n_checks++; if (out_valid !== 1'b0 || enable_auipc !== 1'b0) begin n_fail++; $display("[TB] FAIL filter_auipc_x0: got v%b auipc%b want 0 0", out_valid, enable_auipc); end
`ifdef UTYPE_ILLEGAL_TRAP_EN
    drive(1'b1, 32'h0000_0000, 32'h200); step();
    drive(1'b0, 32'd0, 32'd0);
    n_checks++; if (illegal_valid !== 1'b1 || illegal_pc !== 32'h200) begin n_fail++; $display("[TB] FAIL illegal_pulse: got %b %h want 1 200", illegal_valid, illegal_pc); end
    step();
    n_checks++; if (illegal_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL illegal_one_cycle: got %b want 0", illegal_valid); end
`endif
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h1111_10B7, 32'h400); step();
    drive(1'b1, 32'h2222_2137, 32'h404); step();
    drive(1'b0, 32'd0, 32'd0);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_pre_full: got %b want 0", in_ready); end
    flush = 1'b1; step(); flush = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || enable_lui !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_clear: got v%b rdy%b lui%b want 0 1 0", out_valid, in_ready, enable_lui); end
    drive(1'b1, 32'h5555_52B7, 32'h408); step();
    drive(1'b1, 32'h6666_6337, 32'h40C); flush = 1'b1; step(); flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_with_push: got v%b rdy%b want 0 1", out_valid, in_ready); end
    out_ready = 1'b1; step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_discarded: got %b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h7777_7297, 32'h500); step();
    drive(1'b1, 32'h8888_8337, 32'h504); step();
    drive(1'b0, 32'd0, 32'd0);
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL areset_pre: got rdy%b v%b want 0 1", in_ready, out_valid); end
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL areset_flags: got v%b rdy%b want 0 1", out_valid, in_ready); end
    n_checks++; if (enable_auipc !== 1'b0 || immediate20_utype !== 32'd0 || rd_index !== 5'd0 || pc !== 32'd0) begin n_fail++; $display("[TB] FAIL areset_fields: got %b %h %0d %h want 0 0 0 0", enable_auipc, immediate20_utype, rd_index, pc); end
    mq.delete();
`ifdef UTYPE_ILLEGAL_TRAP_EN
    exp_illegal = 1'b0; exp_illegal_pc = 32'd0;
`endif
    #1 reset_n = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL areset_after: got v%b rdy%b want 0 1", out_valid, in_ready); end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w = {w[31:12], (w[11:7] == 5'd0) ? 5'd3 : w[11:7], 7'h17};
      1: w = {w[31:12], (w[11:7] == 5'd0) ? 5'd9 : w[11:7], 7'h37};
      2: w = {w[31:12], 5'd0, w[5] ? 7'h17 : 7'h37};
      3: w = {w[31:2], 2'b11};
      4: w = {w[31:2], 1'b0, w[0]};
      default: ;
    endcase
    return w;
  endfunction

  task automatic test_random();
    bit          ev;
    bit          ea;
    bit          el;
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 3) != 0, rand_word(), $urandom & 32'hFFFF_FFFC);
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 24) == 0;
      step();
      flush = 1'b0;
      ev = (mq.size() > 0);
      ea = ev && mq[0].auipc;
      el = ev && mq[0].lui;
      n_checks++; if (out_valid !== ev || in_ready !== (mq.size() < 2)) begin n_fail++; $display("[TB] FAIL rand_flags c%0d: got v%b rdy%b want v%b rdy%b", c, out_valid, in_ready, ev, mq.size() < 2); end
      n_checks++; if (enable_auipc !== ea || enable_lui !== el) begin n_fail++; $display("[TB] FAIL rand_enables c%0d: got %b%b want %b%b", c, enable_auipc, enable_lui, ea, el); end
      if (ev) begin
        n_checks++; if (immediate20_utype !== mq[0].imm || rd_index !== mq[0].rd || pc !== mq[0].pc) begin n_fail++; $display("[TB] FAIL rand_fields c%0d: got %h %0d %h want %h %0d %h", c, immediate20_utype, rd_index, pc, mq[0].imm, mq[0].rd, mq[0].pc); end
      end
`ifdef UTYPE_ILLEGAL_TRAP_EN
      n_checks++; if (illegal_valid !== exp_illegal || illegal_pc !== exp_illegal_pc) begin n_fail++; $display("[TB] FAIL rand_illegal c%0d: got %b %h want %b %h", c, illegal_valid, illegal_pc, exp_illegal, exp_illegal_pc); end
`endif
    end
    drive(1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_auipc();
    test_back_to_back();
    test_stall();
    test_filter();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
